// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/ack bus between fetch_stage and imem
interface fetch_stage_if;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: PC, variable-latency imem fetch, IF/RD register
// FETCH_DELAY_SLOT_EN defined: architectural delay slot; undefined: flush on redirect
module fetch_stage #(
  parameter logic [29:0] RESET_PC = 30'h0000000,
  parameter logic [31:0] NOP_INS  = 32'h00000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [29:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic [31:0]          ins,
  output logic [29:0]          pc4,
  output logic                 ins_valid
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic [29:0] pend_pc_q, pend_pc_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] hold_ins_q, hold_ins_d;
  logic [31:0] ins_q, ins_d;
  logic [29:0] pc4_q, pc4_d;
  logic        ins_valid_q, ins_valid_d;

  logic [29:0] pc_plus1;
  logic [29:0] npc;
  logic        load;
  logic        bubble;
  logic [31:0] load_word;

  assign pc_plus1 = pc_q + 30'd1;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    pend_v_d    = pend_v_q;
    hold_ins_d  = hold_ins_q;
    ins_d       = ins_q;
    pc4_d       = pc4_q;
    ins_valid_d = ins_valid_q;
    npc         = pend_v_q ? pend_pc_q : pc_plus1;
    load        = 1'b0;
    bubble      = !stall;
    load_word   = imem.imem_rdata;

`ifdef FETCH_DELAY_SLOT_EN
    // A fresh redirect is the newest target, so it also wins over any older pend_pc.
    if (redirect) begin
      pend_pc_d = redirect_pc;
      pend_v_d  = 1'b1;
      npc       = redirect_pc;
    end
    case (state_q)
      S_HOLD: begin
        if (!stall) begin
          load      = 1'b1;
          load_word = hold_ins_q;
          pc_d      = npc;
          pend_v_d  = 1'b0;
          state_d   = S_REQ;
        end
      end
      default: begin
        if (imem.imem_ack) begin
          if (!stall) begin
            load     = 1'b1;
            pc_d     = npc;
            pend_v_d = 1'b0;
          end else begin
            hold_ins_d = imem.imem_rdata;
            state_d    = S_HOLD;
          end
        end
      end
    endcase
`else
    if (redirect) begin
      bubble = 1'b1;
      case (state_q)
        S_REQ: begin
          if (imem.imem_ack) begin
            pc_d     = redirect_pc;
            pend_v_d = 1'b0;
          end else begin
            // The outstanding request cannot be withdrawn; wait for its ack in DROP.
            pend_pc_d = redirect_pc;
            pend_v_d  = 1'b1;
            state_d   = S_DROP;
          end
        end
        S_HOLD: begin
          pc_d     = redirect_pc;
          pend_v_d = 1'b0;
          state_d  = S_REQ;
        end
        default: begin
          pend_pc_d = redirect_pc;
          if (imem.imem_ack) begin
            pc_d     = redirect_pc;
            pend_v_d = 1'b0;
            state_d  = S_REQ;
          end
        end
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem.imem_ack) begin
            if (!stall) begin
              load     = 1'b1;
              pc_d     = npc;
              pend_v_d = 1'b0;
            end else begin
              hold_ins_d = imem.imem_rdata;
              state_d    = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            load      = 1'b1;
            load_word = hold_ins_q;
            pc_d      = npc;
            pend_v_d  = 1'b0;
            state_d   = S_REQ;
          end
        end
        default: begin
          if (imem.imem_ack) begin
            pc_d     = pend_pc_q;
            pend_v_d = 1'b0;
            state_d  = S_REQ;
          end
        end
      endcase
    end
`endif

    if (load) begin
      ins_d       = load_word;
      pc4_d       = pc_plus1;
      ins_valid_d = 1'b1;
    end else if (bubble) begin
      ins_d       = NOP_INS;
      ins_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      pend_pc_q   <= 30'd0;
      pend_v_q    <= 1'b0;
      hold_ins_q  <= NOP_INS;
      ins_q       <= NOP_INS;
      pc4_q       <= 30'd0;
      ins_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      pend_v_q    <= pend_v_d;
      hold_ins_q  <= hold_ins_d;
      ins_q       <= ins_d;
      pc4_q       <= pc4_d;
      ins_valid_q <= ins_valid_d;
    end
  end

  // Gating with rst_n makes the request fall the instant reset asserts.
  assign imem.imem_req  = rst_n && (state_q != S_HOLD);
  assign imem.imem_addr = pc_q;
  assign ins            = ins_q;
  assign pc4            = pc4_q;
  assign ins_valid      = ins_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized + directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [29:0] redirect_pc;
  logic [31:0] ins;
  logic [29:0] pc4;
  logic        ins_valid;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .ins         (ins),
    .pc4         (pc4),
    .ins_valid   (ins_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: the fetch is either waiting on memory, holding a fetched word,
  // or (flush build) waiting to throw away an abandoned fetch.
  logic [29:0] m_pc, m_pend, m_pc4;
  logic        m_pend_v, m_holding, m_dropping, m_val;
  logic [31:0] m_held, m_ins;

  function automatic logic [31:0] word(input logic [29:0] a);
    return {2'b10, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 30'd0; m_pend = 30'd0; m_pend_v = 1'b0; m_holding = 1'b0; m_dropping = 1'b0;
    m_held = 32'd0; m_ins = 32'd0; m_pc4 = 30'd0; m_val = 1'b0;
  endtask

  task automatic deliver(input logic [31:0] w);
    m_ins = w; m_pc4 = m_pc + 30'd1; m_val = 1'b1;
  endtask

  task automatic model_step(input logic s, input logic r, input logic [29:0] rp,
                            input logic a, input logic [31:0] rd);
    logic [29:0] nxt;
`ifdef FETCH_DELAY_SLOT_EN
    nxt = r ? rp : (m_pend_v ? m_pend : m_pc + 30'd1);
    if (m_holding) begin
      if (!s) begin
        deliver(m_held); m_pc = nxt; m_pend_v = 1'b0; m_holding = 1'b0;
      end else if (r) begin
        m_pend = rp; m_pend_v = 1'b1;
      end
    end else if (a && !s) begin
      deliver(rd); m_pc = nxt; m_pend_v = 1'b0;
    end else begin
      if (a) begin m_held = rd; m_holding = 1'b1; end
      else if (!s) begin m_ins = 32'd0; m_val = 1'b0; end
      if (r) begin m_pend = rp; m_pend_v = 1'b1; end
    end
`else
    nxt = m_pend_v ? m_pend : m_pc + 30'd1;
    if (r) begin
      m_ins = 32'd0; m_val = 1'b0;
      if (m_dropping) begin
        m_pend = rp;
        if (a) begin m_pc = rp; m_pend_v = 1'b0; m_dropping = 1'b0; end
      end else if (m_holding || a) begin
        m_pc = rp; m_pend_v = 1'b0; m_holding = 1'b0;
      end else begin
        m_pend = rp; m_pend_v = 1'b1; m_dropping = 1'b1;
      end
    end else begin
      if (m_dropping) begin
        if (!s) begin m_ins = 32'd0; m_val = 1'b0; end
        if (a) begin m_pc = m_pend; m_pend_v = 1'b0; m_dropping = 1'b0; end
      end else if (m_holding) begin
        if (!s) begin deliver(m_held); m_pc = nxt; m_pend_v = 1'b0; m_holding = 1'b0; end
      end else if (a) begin
        if (s) begin m_held = rd; m_holding = 1'b1; end
        else begin deliver(rd); m_pc = nxt; m_pend_v = 1'b0; end
      end else if (!s) begin
        m_ins = 32'd0; m_val = 1'b0;
      end
    end
`endif
  endtask

  // One cycle: compare DUT against model, apply inputs, advance model.
  task automatic tick(input logic s, input logic r, input logic [29:0] rp, input logic a);
    @(negedge clk);
    chk("imem_req", {31'd0, bus.imem_req}, {31'd0, rst_n && !m_holding});
    chk("imem_addr", {2'b00, bus.imem_addr}, {2'b00, m_pc});
    chk("ins", ins, m_ins);
    chk("pc4", {2'b00, pc4}, {2'b00, m_pc4});
    chk("ins_valid", {31'd0, ins_valid}, {31'd0, m_val});
    stall = s; redirect = r; redirect_pc = rp; bus.imem_ack = a;
    bus.imem_rdata = a ? word(m_pc) : 32'hDEADBEEF;
    model_step(s, r, rp, a, word(m_pc));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 30'd0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0;
    model_reset();
    @(negedge clk);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_valid", {31'd0, ins_valid}, 32'd0);
    chk("rst_pc4", {2'b00, pc4}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Back-to-back fetches from reset
    tick(0, 0, 30'd0, 1);
    chk("t1_ins0", ins, 32'h8000_0000);
    chk("t1_pc4_0", {2'b00, pc4}, 32'd1);
    chk("t1_addr1", {2'b00, bus.imem_addr}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick(0, 0, 30'd0, 1);
      chk("t1_ins", ins, {2'b10, 30'(i)});
    end

    // Ack latency of three cycles
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 30'd0, 0);
      chk("t2_addr", {2'b00, bus.imem_addr}, 32'd4);
      chk("t2_bubble", {31'd0, ins_valid}, 32'd0);
    end
    tick(0, 0, 30'd0, 1);
    chk("t2_ins", ins, 32'h8000_0004);
    chk("t2_pc4", {2'b00, pc4}, 32'd5);

    // Stall across the ack of address 5
    tick(1, 0, 30'd0, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t3_req", {31'd0, bus.imem_req}, 32'd0);
      chk("t3_frozen", ins, 32'h8000_0004);
      tick(1, 0, 30'd0, 0);
    end
    tick(0, 0, 30'd0, 0);
    chk("t3_ins", ins, 32'h8000_0005);
    chk("t3_pc4", {2'b00, pc4}, 32'd6);

    // Redirect to 0x100 while address 7 is outstanding
    tick(0, 0, 30'd0, 1);
    tick(0, 0, 30'd0, 0);
    tick(0, 1, 30'h100, 0);
    chk("t4_addr_kept", {2'b00, bus.imem_addr}, 32'd7);
`ifndef FETCH_DELAY_SLOT_EN
    chk("t4_flush", {31'd0, ins_valid}, 32'd0);
`endif
    tick(0, 0, 30'd0, 1);
    chk("t4_next_addr", {2'b00, bus.imem_addr}, 32'h100);
`ifdef FETCH_DELAY_SLOT_EN
    chk("t5_slot_ins", ins, 32'h8000_0007);
    chk("t5_slot_pc4", {2'b00, pc4}, 32'd8);
    chk("t5_slot_valid", {31'd0, ins_valid}, 32'd1);
`else
    chk("t4_discard", {31'd0, ins_valid}, 32'd0);
`endif
    tick(0, 0, 30'd0, 1);
    chk("t4_target_pc4", {2'b00, pc4}, 32'h101);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic s, r, a;
      logic [29:0] rp;
      s  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 7) == 0);
      rp = ($urandom_range(0, 3) == 0) ? (30'h3FFFFFFF - 30'($urandom_range(0, 2)))
                                       : 30'($urandom);
      a  = !m_holding && ($urandom_range(0, 2) != 0);
      tick(s, r, rp, a);
    end

    // PC wrap at the top of the address space
    tick(0, 0, 30'd0, 0);
    tick(0, 0, 30'd0, 1);
    tick(0, 1, 30'h3FFFFFFF, 1);
    chk("t6_addr_top", {2'b00, bus.imem_addr}, 32'h3FFF_FFFF);
    tick(0, 0, 30'd0, 1);
    chk("t6_wrap_ins", ins, 32'hBFFF_FFFF);
    chk("t6_wrap_pc4", {2'b00, pc4}, 32'd0);
    chk("t6_wrap_addr", {2'b00, bus.imem_addr}, 32'd0);

    // Asynchronous reset mid-request at pc=0x3FFFFFFF
    tick(0, 1, 30'h3FFFFFFF, 1);
    tick(0, 0, 30'd0, 0);
    stall = 1'b0; redirect = 1'b0; bus.imem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("t6_rst_addr", {2'b00, bus.imem_addr}, 32'd0);
    chk("t6_rst_ins", ins, 32'd0);
    chk("t6_rst_valid", {31'd0, ins_valid}, 32'd0);
    chk("t6_rst_pc4", {2'b00, pc4}, 32'd0);
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(0, 0, 30'd0, 1);
    chk("t6_restart_ins", ins, 32'h8000_0002);
    tick(0, 0, 30'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
